// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Resolves per-stage stall requests into per-register stall codes and drives
// the branch flush line. A drain FSM bubbles IF/ID while wrong-path fetches
// are still arriving. Saturating performance counters for stalls and flushes.
module pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_stall_req,
  input  logic             id_stall_req,
  input  logic             ex_stall_req,
  input  logic             mem_stall_req,
  input  logic             branch_error_i,
  output logic [1:0]       stall_pc,
  output logic [1:0]       stall_if_id,
  output logic [1:0]       stall_id_ex,
  output logic [1:0]       stall_ex_mem,
  output logic [1:0]       stall_mem_wb,
  output logic             branch_error_o,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  localparam logic [1:0] PASS = 2'b00;
  localparam logic [1:0] HOLD = 2'b01;
  localparam logic [1:0] BUBB = 2'b10;
  localparam int unsigned DCW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, PEND, DRAIN} state_t;

  state_t         r_state, w_state_nxt;
  logic [DCW-1:0] r_drain_cnt, w_drain_cnt_nxt;
  logic [CNT_W-1:0] r_cnt_stall, r_cnt_flush;

  logic w_drain;
  logic w_if_eff;
  logic w_want_flush;
  logic w_flush;

  // Stall-code resolution: deepest request wins, then drain forcing, then flush override.
  always_comb begin
    w_drain      = (r_state == DRAIN);
    w_if_eff     = if_stall_req & ~w_drain;
    w_want_flush = branch_error_i | (r_state == PEND);
    w_flush      = w_want_flush & ~mem_stall_req;

    stall_pc     = PASS;
    stall_if_id  = PASS;
    stall_id_ex  = PASS;
    stall_ex_mem = PASS;
    stall_mem_wb = PASS;

    if (mem_stall_req) begin
      stall_pc     = HOLD;
      stall_if_id  = HOLD;
      stall_id_ex  = HOLD;
      stall_ex_mem = HOLD;
      stall_mem_wb = BUBB;
    end else if (ex_stall_req) begin
      stall_pc     = HOLD;
      stall_if_id  = HOLD;
      stall_id_ex  = HOLD;
      stall_ex_mem = BUBB;
    end else if (id_stall_req) begin
      stall_pc     = HOLD;
      stall_if_id  = HOLD;
      stall_id_ex  = BUBB;
    end else if (w_if_eff) begin
      stall_pc     = HOLD;
      stall_if_id  = BUBB;
    end else if (w_drain) begin
      stall_if_id  = BUBB;
    end

    // A flush redirects the front end, so it beats shallow (if/id) stalls.
    if (w_flush && !mem_stall_req && !ex_stall_req && (id_stall_req || w_if_eff)) begin
      stall_pc    = PASS;
      stall_if_id = BUBB;
      stall_id_ex = BUBB;
    end

    branch_error_o = w_flush;
  end

  // Drain FSM next state: flush restarts the drain, a blocked flush pends.
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    if (w_flush) begin
      w_state_nxt     = DRAIN;
      w_drain_cnt_nxt = DCW'(DRAIN_CYCLES);
    end else if (w_want_flush) begin
      w_state_nxt     = PEND;
      w_drain_cnt_nxt = '0;
    end else if (w_drain && (stall_pc == PASS)) begin
      w_drain_cnt_nxt = r_drain_cnt - 1'b1;
      if (r_drain_cnt == DCW'(1)) begin
        w_state_nxt = RUN;
      end
    end
  end

  // FSM state and drain counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  // Saturating perf counters for stall cycles and flush pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_stall <= '0;
      r_cnt_flush <= '0;
    end else begin
      if ((stall_pc != PASS) && (r_cnt_stall != '1)) begin
        r_cnt_stall <= r_cnt_stall + 1'b1;
      end
      if (w_flush && (r_cnt_flush != '1)) begin
        r_cnt_flush <= r_cnt_flush + 1'b1;
      end
    end
  end

  assign cnt_stall = r_cnt_stall;
  assign cnt_flush = r_cnt_flush;

endmodule
